// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule definitions: widths, algorithm encoding, FSM states,
// per-algorithm size lookups, round constants and RotWord.
package aes_key_pkg;

    localparam int unsigned KEY_W     = 256;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned MAX_WORDS = 60;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned RND_W     = 4;
    localparam int unsigned BLK_W     = 128;

    localparam logic [1:0] ALG_128  = 2'b00;
    localparam logic [1:0] ALG_192  = 2'b01;
    localparam logic [1:0] ALG_256  = 2'b10;
    localparam logic [1:0] ALG_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_FIN  = 2'd2
    } ks_state_e;

    // Key length in words
    function automatic logic [3:0] nk_of(input logic [1:0] alg);
        case (alg)
            ALG_128: return 4'd4;
            ALG_192: return 4'd6;
            ALG_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    // Number of rounds
    function automatic logic [RND_W-1:0] nr_of(input logic [1:0] alg);
        case (alg)
            ALG_128: return 4'd10;
            ALG_192: return 4'd12;
            ALG_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    // Total schedule words, 4*(Nr+1)
    function automatic logic [IDX_W-1:0] total_of(input logic [1:0] alg);
        case (alg)
            ALG_128: return 6'd44;
            ALG_192: return 6'd52;
            ALG_256: return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    // Round constant Rcon[idx], byte in the top position
    function automatic logic [WORD_W-1:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 32'h0100_0000;
            4'd2:    return 32'h0200_0000;
            4'd3:    return 32'h0400_0000;
            4'd4:    return 32'h0800_0000;
            4'd5:    return 32'h1000_0000;
            4'd6:    return 32'h2000_0000;
            4'd7:    return 32'h4000_0000;
            4'd8:    return 32'h8000_0000;
            4'd9:    return 32'h1b00_0000;
            4'd10:   return 32'h3600_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Cyclic left rotate by one byte
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_schedule_engine_if.sv
// Control/read bus of the key schedule engine.
// master: key consumer (drives start/algorithm/key/rd_round/rd_dec)
// slave : engine (drives busy/done/keys_valid/alg_err/rd_key/rd_err)
interface key_schedule_engine_if;
    import aes_key_pkg::*;

    logic                   start;
    logic [1:0]             algorithm;
    logic [KEY_W-1:0]       key;
    logic                   busy;
    logic                   done;
    logic                   keys_valid;
    logic                   alg_err;
    logic [RND_W-1:0]       rd_round;
    logic                   rd_dec;
    logic [BLK_W-1:0]       rd_key;
    logic                   rd_err;

    modport master (
        output start, algorithm, key, rd_round, rd_dec,
        input  busy, done, keys_valid, alg_err, rd_key, rd_err
    );

    modport slave (
        input  start, algorithm, key, rd_round, rd_dec,
        output busy, done, keys_valid, alg_err, rd_key, rd_err
    );
endinterface

// File: rtl/aes_sub_word.sv
// AES SubWord: four parallel forward S-box lookups, purely combinational.
// i_word   : 32-bit input word
// o_word_c : 32-bit substituted word
module aes_sub_word
    import aes_key_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word_c
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_word_c = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                       SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/key_schedule_engine.sv
// Sequential AES-128/192/256 key expansion: one schedule word per cycle into a
// 60-word store, then 128-bit round keys served by index in encryption or
// reversed (decryption) order with one cycle of read latency.
// clk   : system clock
// rst   : synchronous active-high reset
// s_bus : start/algorithm/key in; busy/done/keys_valid/alg_err status out;
//         rd_round/rd_dec in; registered rd_key/rd_err out
module key_schedule_engine
    import aes_key_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    key_schedule_engine_if.slave  s_bus
);

    ks_state_e              r_state, w_state_nxt;
    logic [WORD_W-1:0]      r_w [MAX_WORDS];
    logic [1:0]             r_alg;
    logic [IDX_W-1:0]       r_i;
    logic [2:0]             r_mod;      // i mod Nk
    logic [3:0]             r_rnd;      // i / Nk
    logic                   r_busy, r_done, r_keys_valid, r_alg_err, r_rd_err;
    logic [BLK_W-1:0]       r_rd_key;

    logic                   w_load, w_gen, w_fin, w_rej;
    logic [IDX_W-1:0]       w_nk, w_last;
    logic [2:0]             w_nk_m1;
    logic [WORD_W-1:0]      w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
    logic [7:0][WORD_W-1:0] w_key_words;
    logic [RND_W-1:0]       w_nr, w_eff;
    logic                   w_rd_ok;
    logic [IDX_W-1:0]       w_base;

    assign w_nk        = IDX_W'(nk_of(r_alg));
    assign w_nk_m1     = 3'(nk_of(r_alg) - 4'd1);
    assign w_last      = total_of(r_alg) - 6'd1;
    assign w_key_words = s_bus.key;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_gen       = 1'b0;
        w_fin       = 1'b0;
        w_rej       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_bus.start) begin
                    if (s_bus.algorithm == ALG_RSVD) begin
                        w_rej = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_GEN;
                    end
                end
            end
            ST_GEN: begin
                w_gen = 1'b1;
                if (r_i == w_last) w_state_nxt = ST_FIN;
            end
            ST_FIN: begin
                w_fin       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next schedule word w[i] from w[i-1] and w[i-Nk]
    assign w_prev   = r_w[r_i - 6'd1];
    assign w_back   = r_w[r_i - w_nk];
    assign w_sub_in = (r_mod == 3'd0) ? rot_word(w_prev) : w_prev;

    aes_sub_word u_sub_word (
        .i_word   (w_sub_in),
        .o_word_c (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0)
            w_temp = w_sub_out ^ rcon(r_rnd);
        else if (r_alg == ALG_256 && r_mod == 3'd4)
            w_temp = w_sub_out;
    end

    assign w_new = w_back ^ w_temp;

    // Word store: key words on load, one expanded word per GEN cycle; no reset needed
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int j = 0; j < 8; j++) begin
                if (4'(j) < nk_of(s_bus.algorithm))
                    r_w[IDX_W'(j)] <= w_key_words[3'(7 - j)];
            end
        end else if (w_gen) begin
            r_w[r_i] <= w_new;
        end
    end

    // Word counter, side counter (i mod Nk, i / Nk) and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alg        <= ALG_128;
            r_i          <= '0;
            r_mod        <= '0;
            r_rnd        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_alg_err    <= 1'b0;
        end else begin
            r_done    <= w_fin;
            r_alg_err <= w_rej;
            if (w_load) begin
                r_alg        <= s_bus.algorithm;
                r_i          <= IDX_W'(nk_of(s_bus.algorithm));
                r_mod        <= 3'd0;
                r_rnd        <= 4'd1;
                r_busy       <= 1'b1;
                r_keys_valid <= 1'b0;
            end else if (w_gen) begin
                r_i <= r_i + 6'd1;
                if (r_mod == w_nk_m1) begin
                    r_mod <= 3'd0;
                    r_rnd <= r_rnd + 4'd1;
                end else begin
                    r_mod <= r_mod + 3'd1;
                end
            end else if (w_fin) begin
                r_busy       <= 1'b0;
                r_keys_valid <= 1'b1;
            end
        end
    end

    // Read port; index forced to 0 on invalid reads so the store is never overrun
    assign w_nr    = nr_of(r_alg);
    assign w_rd_ok = r_keys_valid && (s_bus.rd_round <= w_nr);
    assign w_eff   = s_bus.rd_dec ? (w_nr - s_bus.rd_round) : s_bus.rd_round;
    assign w_base  = w_rd_ok ? {w_eff, 2'b00} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_key <= '0;
            r_rd_err <= 1'b0;
        end else if (w_rd_ok) begin
            r_rd_key <= {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
            r_rd_err <= 1'b0;
        end else begin
            r_rd_key <= '0;
            r_rd_err <= 1'b1;
        end
    end

    assign s_bus.busy       = r_busy;
    assign s_bus.done       = r_done;
    assign s_bus.keys_valid = r_keys_valid;
    assign s_bus.alg_err    = r_alg_err;
    assign s_bus.rd_key     = r_rd_key;
    assign s_bus.rd_err     = r_rd_err;

endmodule

// File: tb/tb_key_schedule_engine.sv
// Self-checking bench for key_schedule_engine: FIPS-197 vectors, error paths,
// restart/reset robustness and randomized keys against a reference expansion.
module tb_key_schedule_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_schedule_engine_if bus_if();

    key_schedule_engine dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus_if)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic         rd_req;
    logic [128:0] exp_q [$];     // {rd_err, rd_key}

    logic [7:0]  sbox_m [256];
    logic [31:0] m_w [60];
    int          m_nr;
    bit          m_valid;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // GF(2^8) arithmetic used to derive the S-box from its definition
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, bv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            bv = inv;
            sbox_m[a] = bv ^ rotl8(bv, 1) ^ rotl8(bv, 2) ^ rotl8(bv, 3) ^ rotl8(bv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] t);
        return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
    endfunction

    // Reference FIPS-197 key expansion with ordinary division and modulo
    task automatic model_expand(input logic [1:0] alg, input logic [255:0] key);
        int nk, total;
        logic [31:0] t;
        logic [7:0]  rc;
        nk    = 4 + 2 * int'(alg);
        m_nr  = nk + 6;
        total = 4 * (m_nr + 1);
        for (int i = 0; i < nk; i++) m_w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < total; i++) begin
            t = m_w[i-1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = sub_w(t);
            end
            m_w[i] = m_w[i-nk] ^ t;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rd_req       = 1'b0;
        bus_if.start = 1'b0;
    endtask

    // Drive a read and queue its expected response
    task automatic issue_read(input logic [3:0] rnd, input logic dec);
        int r;
        logic [128:0] e;
        bus_if.rd_round = rnd;
        bus_if.rd_dec   = dec;
        if (!m_valid || int'(rnd) > m_nr) begin
            e = {1'b1, 128'h0};
        end else begin
            r = dec ? (m_nr - int'(rnd)) : int'(rnd);
            e = {1'b0, m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
        end
        exp_q.push_back(e);
        rd_req = 1'b1;
    endtask

    // Monitor: compares every read response one cycle after issue
    always @(posedge clk) begin
        bit           pend;
        logic [128:0] e;
        pend = rd_req;
        #1;
        if (pend) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                bad_cnt++;
                $display("FAIL scoreboard_empty: got response with no expectation");
            end else begin
                e = exp_q.pop_front();
                check("rd_key", bus_if.rd_key, e[127:0]);
                check("rd_err", 128'(bus_if.rd_err), 128'(e[128]));
            end
        end
    end

    // Start an expansion and follow it to done (or to a mid-run reset)
    task automatic run_expand(input logic [1:0] alg, input logic [255:0] key,
                              input int restart_at, input int rst_at);
        int lat, exp_lat, nk, done_seen;
        nk      = 4 + 2 * int'(alg);
        exp_lat = 4 * (nk + 7) - nk + 1;
        bus_if.algorithm = alg;
        bus_if.key       = key;
        bus_if.start     = 1'b1;
        step();
        m_valid = 0;
        model_expand(alg, key);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 5) issue_read(4'd0, 1'b0);
            if (k == exp_lat) issue_read(4'd0, 1'b0);
            if (k == restart_at) begin
                bus_if.start     = 1'b1;
                bus_if.algorithm = 2'b10;
                bus_if.key       = ~key;
            end
            if (k == rst_at) rst = 1'b1;
            step();
            if (k == 5) begin
                check("busy_in_gen", 128'(bus_if.busy), 128'(1));
                check("kv_in_gen", 128'(bus_if.keys_valid), 128'(0));
            end
            if (k == rst_at) begin
                rst = 1'b0;
                check("rst_busy", 128'(bus_if.busy), 128'(0));
                check("rst_kv", 128'(bus_if.keys_valid), 128'(0));
                done_seen = 0;
                for (int c = 0; c < 60; c++) begin
                    if (bus_if.done) done_seen++;
                    step();
                end
                check("rst_no_done", 128'(done_seen), 128'(0));
                check("rst_kv_after", 128'(bus_if.keys_valid), 128'(0));
                return;
            end
            if (bus_if.done) begin
                lat = k;
                break;
            end
        end
        check("done_latency", 128'(lat), 128'(exp_lat));
        if (lat > 0) m_valid = 1;
        check("kv_after_done", 128'(bus_if.keys_valid), 128'(1));
        check("busy_after_done", 128'(bus_if.busy), 128'(0));
        step();
        check("done_pulse", 128'(bus_if.done), 128'(0));
    endtask

    initial begin
        logic [255:0] k128, k192, k256, rk;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k128, k192, k256, rk;
        logic [1:0]   ra;
        build_sbox();
        rst = 1'b1;
        rd_req = 1'b0;
        m_valid = 0;
        m_nr = 10;
        bus_if.start = 1'b0;
        bus_if.algorithm = 2'b00;
        bus_if.key = '0;
        bus_if.rd_round = 4'd0;
        bus_if.rd_dec = 1'b0;
        repeat (3) step();
        check("rst_busy0", 128'(bus_if.busy), 128'(0));
        check("rst_done0", 128'(bus_if.done), 128'(0));
        check("rst_kv0", 128'(bus_if.keys_valid), 128'(0));
        check("rst_alg_err0", 128'(bus_if.alg_err), 128'(0));
        check("rst_rd_err0", 128'(bus_if.rd_err), 128'(0));
        check("rst_rd_key0", bus_if.rd_key, 128'h0);
        rst = 1'b0;
        step();

        // AES-128 FIPS-197 vector
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        run_expand(2'b00, k128, 0, 0);
        issue_read(4'd10, 1'b0); step();
        check("aes128_r10", bus_if.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        issue_read(4'd0, 1'b1); step();
        check("aes128_dec0", bus_if.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        issue_read(4'd11, 1'b0); step();
        check("aes128_r11_err", 128'(bus_if.rd_err), 128'(1));
        check("aes128_r11_key", bus_if.rd_key, 128'h0);

        // AES-192 FIPS-197 vector
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        run_expand(2'b01, k192, 0, 0);
        issue_read(4'd12, 1'b0); step();
        check("aes192_r12", bus_if.rd_key, 128'he98ba06f448c773c8ecc720401002202);
        issue_read(4'd0, 1'b0); step();
        check("aes192_r0", bus_if.rd_key, 128'h8e73b0f7da0e6452c810f32b809079e5);

        // AES-256 FIPS-197 vector
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        run_expand(2'b10, k256, 0, 0);
        issue_read(4'd14, 1'b0); step();
        check("aes256_r14", bus_if.rd_key, 128'hfe4890d1e6188d0b046df344706c631e);
        for (int r = 0; r < 15; r++) begin
            issue_read(4'(r), 1'b1);
            step();
        end

        // Reserved algorithm: one-cycle alg_err, schedule untouched
        bus_if.algorithm = 2'b11;
        bus_if.start     = 1'b1;
        step();
        check("alg_err_pulse", 128'(bus_if.alg_err), 128'(1));
        check("alg_err_busy", 128'(bus_if.busy), 128'(0));
        check("alg_err_kv", 128'(bus_if.keys_valid), 128'(1));
        step();
        check("alg_err_clear", 128'(bus_if.alg_err), 128'(0));
        check("alg_err_busy2", 128'(bus_if.busy), 128'(0));
        issue_read(4'd14, 1'b0); step();

        // Restart while busy is ignored
        run_expand(2'b00, k128, 10, 0);
        issue_read(4'd10, 1'b0); step();
        check("restart_ignored_r10", bus_if.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset mid-GEN, then a fresh run
        run_expand(2'b00, k128, 0, 20);
        issue_read(4'd3, 1'b0); step();
        run_expand(2'b00, k128, 0, 0);
        issue_read(4'd10, 1'b0); step();
        check("after_rst_r10", bus_if.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Randomized keys and reads against the reference model
        for (int t = 0; t < 6; t++) begin
            ra = 2'($urandom_range(0, 2));
            rk = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            run_expand(ra, rk, 0, 0);
            for (int n = 0; n < 12; n++) begin
                issue_read(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                step();
            end
        end

        step();
        step();
        check("scoreboard_drain", 128'(exp_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/key_schedule_engine.md
Name: key_schedule_engine

Overview:
Sequential AES key-expansion engine for AES-128, AES-192 and AES-256. On a start pulse it generates one 32-bit schedule word per cycle into an internal word store. It then serves 128-bit round keys by index, in either encryption order or reversed decryption order. It feeds the inverse-cipher datapath, which consumes round keys last-to-first, and replaces the fully unrolled combinational expansion.

Parameters:
KEY_W, 256, key input width; shorter keys are left-justified.
WORD_W, 32, schedule word width.
MAX_WORDS, 60, depth of the word store, 4*(14+1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to expand key
algorithm  in  2  2'b00=AES-128, 2'b01=AES-192, 2'b10=AES-256, 2'b11 reserved
key  in  256  cipher key; AES-128 uses [255:128], AES-192 uses [255:64], AES-256 uses all bits
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when the schedule is complete
keys_valid  out  1  the store holds a complete schedule for the latched algorithm
alg_err  out  1  one-cycle pulse when start is rejected for algorithm 2'b11
rd_round  in  4  requested round index, 0..Nr
rd_dec  in  1  0 = encryption order (key rd_round); 1 = decryption order (key Nr-rd_round)
rd_key  out  128  registered round key; w[4r] occupies [127:96]
rd_err  out  1  registered; the read was invalid

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: busy, done, keys_valid, alg_err, rd_err = 0; rd_key = 0; FSM = IDLE. Word store contents are don't-care after reset.
- Key sizes by algorithm:
  - AES-128: Nk=4, Nr=10, total=44 words.
  - AES-192: Nk=6, Nr=12, total=52 words.
  - AES-256: Nk=8, Nr=14, total=60 words.
- FSM states: IDLE, GEN, FIN.
- IDLE:
  - start with algorithm != 2'b11: latch algorithm, write w[0..Nk-1] from key in one cycle, set the word counter to Nk, set busy=1, clear keys_valid, go to GEN.
  - start with algorithm = 2'b11: pulse alg_err; all other state is unchanged.
- GEN, one word per cycle, per FIPS-197:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ Rcon[i/Nk].
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; then i increments.
  - After writing w[total-1], go to FIN.
  - i mod Nk and i/Nk come from a side counter that wraps at Nk. No divider is used.
- FIN: pulse done, set keys_valid=1, set busy=0, return to IDLE.
- Latency: the start edge is cycle 0. done is high in cycle total-Nk+1, i.e. 41, 47 or 53.
- start while busy is ignored: no restart, no error.
- Reset asserted mid-GEN returns to IDLE. keys_valid stays 0 and no done pulse is produced.
- Read port: 1-cycle latency.
  - Effective index r = rd_dec ? Nr-rd_round : rd_round.
  - rd_key <= {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
  - If keys_valid=0 or rd_round>Nr: rd_key <= 0 and rd_err <= 1; otherwise rd_err <= 0.
- Reads during GEN therefore return zero with rd_err=1.
- A read in the same cycle as the done pulse is invalid; the first valid read is the one issued in the cycle after done.

Decomposition:
- Shared package aes_key_pkg:
  - algorithm encoding constants;
  - Nk, Nr and total-word lookup functions;
  - Rcon table (01,02,04,08,10,20,40,80,1b,36) in the top byte;
  - RotWord function.
- One sub-module, aes_sub_word: four parallel S-box lookups, combinational, 32-bit in and out. It is shared with the cipher datapath.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start:
  - done at cycle 41;
  - rd_round=10, rd_dec=0 gives rd_key d014f9a8c9ee2589e13f0cc8b6630ca6;
  - rd_round=0, rd_dec=1 gives the same value.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b left-justified:
  - done at cycle 47;
  - round 12 gives e98ba06f448c773c8ecc720401002202;
  - round 0 gives the key's first 128 bits.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done at cycle 53;
  - round 14 gives fe4890d1e6188d0b046df344706c631e;
  - this exercises the i mod 8 == 4 SubWord path.
- Error paths:
  - rd_round=11 after AES-128 gives rd_key=0, rd_err=1;
  - read during GEN gives rd_err=1;
  - algorithm=2'b11 with start gives a one-cycle alg_err and busy stays 0.
- Robustness:
  - start pulsed again at cycle 10 of an AES-128 run: ignored, done still at cycle 41;
  - rst at cycle 20: busy=0, keys_valid=0, no done;
  - a fresh start then completes correctly.
